// File: rtl/vote_rf_pkg.sv
// Shared types and default parameters for the voted register file.
// The FSM state type lives here so the top and any future sub-blocks agree on encoding.
package vote_rf_pkg;

    localparam int NCH_DEF    = 3;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALT    = 2'd1,
        RECOVER = 2'd2
    } state_t;

endpackage

// File: rtl/vote_rf_voter.sv
// Combinational voter: picks the committed write tuple from redundant channels
// and reports which channels disagree with the outcome.
module vote_rf_voter
    import vote_rf_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [NCH-1:0]             i_we,
    input  logic [NCH-1:0][ADDR_W-1:0] i_addr,
    input  logic [NCH-1:0][DATA_W-1:0] i_data,
    output logic                       o_we,
    output logic [ADDR_W-1:0]          o_addr,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_valid,
    output logic [NCH-1:0]             o_fault
);

    // Idle channels agree regardless of their address/data lines.
    function automatic logic f_agree(
        input logic              weA,
        input logic              weB,
        input logic [ADDR_W-1:0] addrA,
        input logic [ADDR_W-1:0] addrB,
        input logic [DATA_W-1:0] dataA,
        input logic [DATA_W-1:0] dataB
    );
        return (!weA && !weB) || (weA && weB && (addrA == addrB) && (dataA == dataB));
    endfunction

    generate
        if (NCH == 3) begin : g_tmr
            logic w_a01;
            logic w_a02;
            logic w_a12;

            assign w_a01 = f_agree(i_we[0], i_we[1], i_addr[0], i_addr[1], i_data[0], i_data[1]);
            assign w_a02 = f_agree(i_we[0], i_we[2], i_addr[0], i_addr[2], i_data[0], i_data[2]);
            assign w_a12 = f_agree(i_we[1], i_we[2], i_addr[1], i_addr[2], i_data[1], i_data[2]);

            // Agreement is transitive, so a single failing pair pins down the outlier.
            always_comb begin
                o_we    = i_we[0];
                o_addr  = i_addr[0];
                o_data  = i_data[0];
                o_valid = 1'b1;
                o_fault = '0;
                if (!w_a01 || !w_a02) begin
                    if (w_a01) begin
                        o_fault = 3'b100;
                    end else if (w_a02) begin
                        o_fault = 3'b010;
                    end else if (w_a12) begin
                        o_we    = i_we[1];
                        o_addr  = i_addr[1];
                        o_data  = i_data[1];
                        o_fault = 3'b001;
                    end else begin
                        o_valid = 1'b0;
                        o_fault = '1;
                    end
                end
            end
        end else begin : g_dmr
            logic w_a01;

            assign w_a01 = f_agree(i_we[0], i_we[1], i_addr[0], i_addr[1], i_data[0], i_data[1]);

            always_comb begin
                o_we    = i_we[0];
                o_addr  = i_addr[0];
                o_data  = i_data[0];
                o_valid = w_a01;
                o_fault = w_a01 ? '0 : '1;
            end
        end
    endgenerate

endmodule

// File: rtl/vote_rf.sv
// Register file with redundant (DMR/TMR) write channels, a vote-driven halt
// mechanism and a saturating mismatch counter.
module vote_rf
    import vote_rf_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCH-1:0]             we_i,
    input  logic [NCH-1:0][ADDR_W-1:0] waddr_i,
    input  logic [NCH-1:0][DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]          raddr_a_i,
    input  logic [ADDR_W-1:0]          raddr_b_i,
    output logic [DATA_W-1:0]          rdata_a_o,
    output logic [DATA_W-1:0]          rdata_b_o,
    input  logic                       recover_i,
    output logic                       signal_o,
    output logic [NCH-1:0]             fault_ch_o,
    output logic                       halt_o,
    output logic [CNT_W-1:0]           err_cnt_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic              r_signal;
    logic [NCH-1:0]    r_fault;
    logic [CNT_W-1:0]  r_errCnt;

    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_valid;
    logic [NCH-1:0]    w_fault;
    logic              w_mismatch;

    vote_rf_voter #(
        .NCH    (NCH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_voter (
        .i_we    (we_i),
        .i_addr  (waddr_i),
        .i_data  (wdata_i),
        .o_we    (w_we),
        .o_addr  (w_addr),
        .o_data  (w_data),
        .o_valid (w_valid),
        .o_fault (w_fault)
    );

    assign w_mismatch = |w_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_state  <= RUN;
            r_signal <= 1'b0;
            r_fault  <= '0;
            r_errCnt <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_valid && w_we && (w_addr != '0)) begin
                        r_mem[w_addr] <= w_data;
                    end
                    r_fault  <= w_fault;
                    r_signal <= w_mismatch;
                    if (w_mismatch && (r_errCnt != {CNT_W{1'b1}})) begin
                        r_errCnt <= r_errCnt + CNT_W'(1);
                    end
                    if (!w_valid) begin
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    if (recover_i) begin
                        r_state <= RECOVER;
                        r_signal <= 1'b0;
                        r_fault  <= '0;
                    end
                end
                RECOVER: begin
                    r_signal <= 1'b0;
                    r_fault  <= '0;
                    r_state  <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    // Address 0 is hard-wired to zero on the read side as well.
    assign rdata_a_o  = (raddr_a_i == '0) ? '0 : r_mem[raddr_a_i];
    assign rdata_b_o  = (raddr_b_i == '0) ? '0 : r_mem[raddr_b_i];
    assign signal_o   = r_signal;
    assign fault_ch_o = r_fault;
    assign halt_o     = (r_state == HALT);
    assign err_cnt_o  = r_errCnt;

endmodule

// File: tb/tb_vote_rf.sv
// Directed bench for vote_rf: a TMR instance with a 2-bit counter and a DMR instance.
module tb_vote_rf;

    logic clk;
    logic rst;

    logic [2:0]       we3;
    logic [2:0][4:0]  waddr3;
    logic [2:0][31:0] wdata3;
    logic [4:0]       raddrA3, raddrB3;
    logic [31:0]      rdataA3, rdataB3;
    logic             recover3, signal3, halt3;
    logic [2:0]       fault3;
    logic [1:0]       cnt3;

    logic [1:0]       we2;
    logic [1:0][4:0]  waddr2;
    logic [1:0][31:0] wdata2;
    logic [4:0]       raddrA2, raddrB2;
    logic [31:0]      rdataA2, rdataB2;
    logic             recover2, signal2, halt2;
    logic [1:0]       fault2;
    logic [7:0]       cnt2;

    int nAssert = 0;
    int nFail   = 0;

    vote_rf #(.NCH(3), .ADDR_W(5), .DATA_W(32), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .we_i(we3), .waddr_i(waddr3), .wdata_i(wdata3),
        .raddr_a_i(raddrA3), .raddr_b_i(raddrB3), .rdata_a_o(rdataA3), .rdata_b_o(rdataB3),
        .recover_i(recover3), .signal_o(signal3), .fault_ch_o(fault3), .halt_o(halt3),
        .err_cnt_o(cnt3)
    );

    vote_rf #(.NCH(2), .ADDR_W(5), .DATA_W(32), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .we_i(we2), .waddr_i(waddr2), .wdata_i(wdata2),
        .raddr_a_i(raddrA2), .raddr_b_i(raddrB2), .rdata_a_o(rdataA2), .rdata_b_o(rdataB2),
        .recover_i(recover2), .signal_o(signal2), .fault_ch_o(fault2), .halt_o(halt2),
        .err_cnt_o(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAssert++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setWrite3(input int ch, input logic we, input logic [4:0] a, input logic [31:0] d);
        we3[ch]    = we;
        waddr3[ch] = a;
        wdata3[ch] = d;
    endtask

    task automatic setWrite2(input int ch, input logic we, input logic [4:0] a, input logic [31:0] d);
        we2[ch]    = we;
        waddr2[ch] = a;
        wdata2[ch] = d;
    endtask

    task automatic idleAll();
        we3 = '0; waddr3 = '0; wdata3 = '0; recover3 = 1'b0;
        we2 = '0; waddr2 = '0; wdata2 = '0; recover2 = 1'b0;
    endtask

    initial begin
        idleAll();
        raddrA3 = '0; raddrB3 = '0; raddrA2 = '0; raddrB2 = '0;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("rst_halt3", 32'(halt3), 32'd0);
        checkOutput("rst_signal3", 32'(signal3), 32'd0);
        checkOutput("rst_fault3", 32'(fault3), 32'd0);
        checkOutput("rst_cnt3", 32'(cnt3), 32'd0);
        checkOutput("rst_halt2", 32'(halt2), 32'd0);
        checkOutput("rst_cnt2", 32'(cnt2), 32'd0);

        // DMR: agreed write, then a data disagreement that must halt
        setWrite2(0, 1'b1, 5'd5, 32'd33); setWrite2(1, 1'b1, 5'd5, 32'd33);
        raddrA2 = 5'd5;
        applyStimulus();
        checkOutput("dmr_agree_rd5", rdataA2, 32'd33);
        checkOutput("dmr_agree_signal", 32'(signal2), 32'd0);
        setWrite2(0, 1'b1, 5'd5, 32'd100); setWrite2(1, 1'b1, 5'd5, 32'd101);
        applyStimulus();
        checkOutput("dmr_mis_rd5", rdataA2, 32'd33);
        checkOutput("dmr_mis_halt", 32'(halt2), 32'd1);
        checkOutput("dmr_mis_fault", 32'(fault2), 32'd3);
        checkOutput("dmr_mis_signal", 32'(signal2), 32'd1);
        checkOutput("dmr_mis_cnt", 32'(cnt2), 32'd1);

        setWrite2(0, 1'b1, 5'd6, 32'd7); setWrite2(1, 1'b1, 5'd6, 32'd7);
        raddrB2 = 5'd6;
        applyStimulus();
        checkOutput("dmr_halt_rd6", rdataB2, 32'd0);
        checkOutput("dmr_halt_halt", 32'(halt2), 32'd1);
        checkOutput("dmr_halt_signal", 32'(signal2), 32'd1);
        checkOutput("dmr_halt_fault", 32'(fault2), 32'd3);
        checkOutput("dmr_halt_cnt", 32'(cnt2), 32'd1);

        recover2 = 1'b1;
        applyStimulus();
        checkOutput("dmr_rec_halt", 32'(halt2), 32'd0);
        checkOutput("dmr_rec_signal", 32'(signal2), 32'd0);
        checkOutput("dmr_rec_fault", 32'(fault2), 32'd0);
        checkOutput("dmr_rec_rd6", rdataB2, 32'd0);
        recover2 = 1'b0;
        applyStimulus();
        checkOutput("dmr_rec2_rd6", rdataB2, 32'd0);
        checkOutput("dmr_rec2_halt", 32'(halt2), 32'd0);
        recover2 = 1'b1;
        applyStimulus();
        checkOutput("dmr_run_rd6", rdataB2, 32'd7);
        checkOutput("dmr_run_halt", 32'(halt2), 32'd0);
        checkOutput("dmr_run_signal", 32'(signal2), 32'd0);
        checkOutput("dmr_run_cnt", 32'(cnt2), 32'd1);
        idleAll();

        // TMR: unanimous write
        for (int c = 0; c < 3; c++) setWrite3(c, 1'b1, 5'd11, 32'd100);
        raddrA3 = 5'd11;
        applyStimulus();
        checkOutput("tmr_all_rd11", rdataA3, 32'd100);
        checkOutput("tmr_all_signal", 32'(signal3), 32'd0);
        checkOutput("tmr_all_cnt", 32'(cnt3), 32'd0);

        // TMR: channel 2 outlier on a different address
        setWrite3(2, 1'b1, 5'd10, 32'd120);
        raddrB3 = 5'd10;
        applyStimulus();
        checkOutput("tmr_ch2_rd11", rdataA3, 32'd100);
        checkOutput("tmr_ch2_rd10", rdataB3, 32'd0);
        checkOutput("tmr_ch2_fault", 32'(fault3), 32'd4);
        checkOutput("tmr_ch2_signal", 32'(signal3), 32'd1);
        checkOutput("tmr_ch2_cnt", 32'(cnt3), 32'd1);
        checkOutput("tmr_ch2_halt", 32'(halt3), 32'd0);

        idleAll();
        applyStimulus();
        checkOutput("tmr_idle_signal", 32'(signal3), 32'd0);
        checkOutput("tmr_idle_fault", 32'(fault3), 32'd0);
        checkOutput("tmr_idle_cnt", 32'(cnt3), 32'd1);

        for (int c = 0; c < 3; c++) setWrite3(c, 1'b1, 5'd0, 32'd55);
        raddrA3 = 5'd0;
        applyStimulus();
        checkOutput("tmr_addr0_rd", rdataA3, 32'd0);

        // Same-cycle write and read must return the old value
        for (int c = 0; c < 3; c++) setWrite3(c, 1'b1, 5'd12, 32'd77);
        raddrB3 = 5'd12;
        #1;
        checkOutput("tmr_nobypass_rd12", rdataB3, 32'd0);
        applyStimulus();
        checkOutput("tmr_after_rd12", rdataB3, 32'd77);

        setWrite3(0, 1'b1, 5'd13, 32'd5); setWrite3(1, 1'b1, 5'd13, 32'd6); setWrite3(2, 1'b1, 5'd13, 32'd5);
        raddrA3 = 5'd13;
        applyStimulus();
        checkOutput("tmr_ch1_rd13", rdataA3, 32'd5);
        checkOutput("tmr_ch1_fault", 32'(fault3), 32'd2);
        checkOutput("tmr_ch1_cnt", 32'(cnt3), 32'd2);

        setWrite3(0, 1'b0, 5'd0, 32'd0); setWrite3(1, 1'b1, 5'd14, 32'd9); setWrite3(2, 1'b1, 5'd14, 32'd9);
        raddrA3 = 5'd14;
        applyStimulus();
        checkOutput("tmr_ch0_rd14", rdataA3, 32'd9);
        checkOutput("tmr_ch0_fault", 32'(fault3), 32'd1);
        checkOutput("tmr_ch0_cnt", 32'(cnt3), 32'd3);

        setWrite3(0, 1'b1, 5'd14, 32'd9); setWrite3(1, 1'b1, 5'd14, 32'd9); setWrite3(2, 1'b1, 5'd14, 32'd8);
        applyStimulus();
        checkOutput("tmr_sat_cnt", 32'(cnt3), 32'd3);
        checkOutput("tmr_sat_fault", 32'(fault3), 32'd4);

        // TMR: three-way disagreement halts
        setWrite3(0, 1'b1, 5'd15, 32'd1); setWrite3(1, 1'b1, 5'd15, 32'd2); setWrite3(2, 1'b1, 5'd15, 32'd3);
        raddrA3 = 5'd15;
        applyStimulus();
        checkOutput("tmr_3way_rd15", rdataA3, 32'd0);
        checkOutput("tmr_3way_halt", 32'(halt3), 32'd1);
        checkOutput("tmr_3way_fault", 32'(fault3), 32'd7);
        checkOutput("tmr_3way_signal", 32'(signal3), 32'd1);
        checkOutput("tmr_3way_cnt", 32'(cnt3), 32'd3);

        for (int c = 0; c < 3; c++) setWrite3(c, 1'b1, 5'd16, 32'd44);
        raddrB3 = 5'd16;
        applyStimulus();
        checkOutput("tmr_halt_rd16", rdataB3, 32'd0);
        checkOutput("tmr_halt_halt", 32'(halt3), 32'd1);
        checkOutput("tmr_halt_fault", 32'(fault3), 32'd7);

        // Reset while halted, with a competing agreed write
        for (int c = 0; c < 3; c++) setWrite3(c, 1'b1, 5'd17, 32'd9);
        recover2 = 1'b1;
        raddrA3 = 5'd11; raddrB3 = 5'd17;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        idleAll();
        checkOutput("rst2_halt3", 32'(halt3), 32'd0);
        checkOutput("rst2_signal3", 32'(signal3), 32'd0);
        checkOutput("rst2_fault3", 32'(fault3), 32'd0);
        checkOutput("rst2_cnt3", 32'(cnt3), 32'd0);
        checkOutput("rst2_rd11", rdataA3, 32'd0);
        checkOutput("rst2_rd17", rdataB3, 32'd0);
        checkOutput("rst2_cnt2", 32'(cnt2), 32'd0);
        checkOutput("rst2_rd6_dmr", rdataB2, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
